fp8_mul_arbiter: RTL and testbench

//   Shares one approximate FP8 (E4M3: 1 sign, 4 exp, 3 mantissa, bias 7) multiplier among N_REQ requesters.

---
 rtl/fp8_mul_arbiter_if.sv | 26 ++
 rtl/fp8_mul_arbiter.sv | 121 ++++++++++++
 tb/tb_fp8_mul_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp8_mul_arbiter_if.sv
// Request/result bundle for the shared FP8 multiplier: N_REQ packed operand
// ports on the request side and one tagged result port.
interface fp8_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [7:0]         res_data;
  logic [ID_W-1:0]    res_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/fp8_mul_arbiter.sv
// Round-robin arbiter in front of one approximate E4M3 multiplier, followed by a
// two-register (operand, result) pipeline with valid/ready backpressure.
module fp8_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int BIAS  = 7
) (
  input logic              clk,
  input logic              rst,
  fp8_mul_arbiter_if.slave bus
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic            found;
  logic            s1_valid;
  logic [7:0]      s1_a;
  logic [7:0]      s1_b;
  logic [ID_W-1:0] s1_id;
  logic            res_valid;
  logic [7:0]      res_data;
  logic [ID_W-1:0] res_id;
  logic            s2_load;
  logic            s1_adv;
  logic            accept;
  logic            hs;

  // Mantissa product approximated by adding remapped 3-bit mantissas; Ce is the
  // exponent correction for that remap.
  function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] xa;
    logic [3:0] xb;
    logic [3:0] t;
    logic [3:0] e;
    logic [2:0] m;
    logic       ce;
    xa = a[2] ? {2'b11, a[2:1]} : {1'b0, a[2:0]};
    xb = b[2] ? {2'b11, b[2:1]} : {1'b0, b[2:0]};
    t  = xa + xb;
    ce = (a[2] & b[2]) | ((a[2] | b[2]) & ~t[3]);
    e  = a[6:3] + b[6:3] - 4'(BIAS) - {3'b000, ce};
    m  = t[3] ? {t[1:0], 1'b0} : t[2:0];
    return {a[7] ^ b[7], e, m};
  endfunction

  assign s2_load = ~res_valid | bus.res_ready;
  assign s1_adv  = s1_valid & s2_load;
  assign accept  = ~s1_valid | s1_adv;
  assign hs      = accept & ~rst & found;

  // Two constant-index passes: first from rr_ptr upward, then wrap from 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    found  = 1'b0;
    winner = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
        sel_a  = bus.req_a[8*i +: 8];
        sel_b  = bus.req_b[8*i +: 8];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
        sel_a  = bus.req_a[8*i +: 8];
        sel_b  = bus.req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      bus.req_ready[i] = hs && (winner == ID_W'(i));
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      if (hs) begin
        s1_valid <= 1'b1;
        s1_id    <= winner;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        rr_ptr   <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_data <= fp8_mul(s1_a, s1_b);
          res_id   <= s1_id;
        end
      end
    end
  end
  // NOTE: s1_a/s1_b/s1_id are payload qualified by s1_valid, so they carry no
  // reset; only the valid bits and the visible outputs are cleared.

  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_id    = res_id;
  assign bus.busy      = s1_valid | res_valid;

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Directed bench for fp8_mul_arbiter: arithmetic table, arbitration table and
// hand-written stall / reset sequences, all with hand-computed expectations.
module tb_fp8_mul_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp8_mul_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

  fp8_mul_arbiter #(.N_REQ(4), .ID_W(2), .BIAS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prod;
  } vec_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } arb_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    cyc();
    rst = 1'b1;
    bus.req_valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[7];
  arb_t arbs[7];
  int   hs_count;
  int   j;

  initial begin
    vecs[0] = '{8'h38, 8'h38, 8'h38};
    vecs[1] = '{8'h40, 8'hB8, 8'hC0};
    vecs[2] = '{8'h3A, 8'h39, 8'h3B};
    vecs[3] = '{8'h3C, 8'h3C, 8'h30};
    vecs[4] = '{8'h08, 8'h08, 8'h58};
    vecs[5] = '{8'h3E, 8'h3A, 8'h31};
    vecs[6] = '{8'h38, 8'h3F, 8'h3E};

    arbs[0] = '{4'b0010, 4'b0010};
    arbs[1] = '{4'b1011, 4'b1000};
    arbs[2] = '{4'b0011, 4'b0001};
    arbs[3] = '{4'b0010, 4'b0010};
    arbs[4] = '{4'b1011, 4'b1000};
    arbs[5] = '{4'b0001, 4'b0001};
    arbs[6] = '{4'b0100, 4'b0100};

    // Reset state, with every requester asserting valid during reset.
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    cyc();
    cyc();
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_res_data",  32'(bus.res_data),  32'h0);
    check("rst_res_id",    32'(bus.res_id),    32'h0);
    rst           = 1'b0;
    bus.req_valid = '0;

    // Arithmetic table: one requester at a time, rotating the requester index.
    for (int i = 0; i < 7; i++) begin
      j = i % 4;
      cyc();
      bus.req_valid = 4'(1 << j);
      bus.req_a     = 32'(vecs[i].a) << (8 * j);
      bus.req_b     = 32'(vecs[i].b) << (8 * j);
      #1;
      check("vec_ready", 32'(bus.req_ready), 32'(1 << j));
      cyc();
      bus.req_valid = '0;
      #1;
      check("vec_early_valid", 32'(bus.res_valid), 32'h0);
      cyc();
      #1;
      check("vec_res_valid", 32'(bus.res_valid), 32'h1);
      check("vec_res_data",  32'(bus.res_data),  32'(vecs[i].prod));
      check("vec_res_id",    32'(bus.res_id),    32'(j));
    end

    // All four requesters valid: one grant per cycle, results stream back to back.
    reset_pulse();
    bus.req_a = {8'h3B, 8'h3A, 8'h39, 8'h38};
    bus.req_b = {4{8'h38}};
    for (int c = 0; c < 8; c++) begin
      cyc();
      bus.req_valid = 4'b1111;
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("rr_res_valid", 32'(bus.res_valid), 32'h1);
        check("rr_res_id",    32'(bus.res_id),    32'((c - 2) % 4));
        check("rr_res_data",  32'(bus.res_data),  32'(8'h38 + (c - 2) % 4));
      end else begin
        check("rr_res_idle", 32'(bus.res_valid), 32'h0);
      end
    end
    cyc();
    bus.req_valid = '0;
    cyc();
    cyc();

    // Pointer table: reaches rr_ptr=2, then grants 3,0,1; dropped req1 does not stall.
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      cyc();
      bus.req_valid = arbs[i].valid;
      #1;
      check("arb_ready", 32'(bus.req_ready), 32'(arbs[i].ready));
    end
    cyc();
    bus.req_valid = '0;
    cyc();
    cyc();

    // Backpressure: two handshakes fill the pipe, then grants stop and data holds.
    reset_pulse();
    bus.req_a = {8'h00, 8'h00, 8'h3A, 8'h40};
    bus.req_b = {8'h00, 8'h00, 8'h39, 8'hB8};
    hs_count  = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0011;
      #1;
      if (bus.req_ready != '0) hs_count++;
      check("stall_ready", 32'(bus.req_ready), (c == 0) ? 32'h1 : (c == 1) ? 32'h2 : 32'h0);
      if (c >= 2) begin
        check("stall_valid", 32'(bus.res_valid), 32'h1);
        check("stall_id",    32'(bus.res_id),    32'h0);
        check("stall_data",  32'(bus.res_data),  32'hC0);
      end
    end
    check("stall_hs_count", 32'(hs_count), 32'h2);
    cyc();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    #1;
    check("drain0_valid", 32'(bus.res_valid), 32'h1);
    check("drain0_id",    32'(bus.res_id),    32'h0);
    check("drain0_data",  32'(bus.res_data),  32'hC0);
    cyc();
    #1;
    check("drain1_valid", 32'(bus.res_valid), 32'h1);
    check("drain1_id",    32'(bus.res_id),    32'h1);
    check("drain1_data",  32'(bus.res_data),  32'h3B);
    cyc();
    #1;
    check("drain_done_valid", 32'(bus.res_valid), 32'h0);
    check("drain_done_busy",  32'(bus.busy),      32'h0);

    // Reset with both stages full: in-flight work is dropped, pointer returns to 0.
    reset_pulse();
    bus.req_a = {8'h00, 8'h00, 8'h3C, 8'h38};
    bus.req_b = {8'h00, 8'h00, 8'h3C, 8'h38};
    cyc();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    check("full_ready0", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = 4'b0010;
    #1;
    check("full_ready1", 32'(bus.req_ready), 32'h2);
    cyc();
    bus.req_valid = '0;
    #1;
    check("full_busy",  32'(bus.busy),      32'h1);
    check("full_valid", 32'(bus.res_valid), 32'h1);
    rst           = 1'b1;
    bus.req_valid = 4'b0011;
    #1;
    check("in_rst_ready", 32'(bus.req_ready), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_valid", 32'(bus.res_valid), 32'h0);
    check("post_rst_busy",  32'(bus.busy),      32'h0);
    check("post_rst_data",  32'(bus.res_data),  32'h0);
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    #1;
    check("post_rst_s1", 32'(bus.res_valid), 32'h0);
    cyc();
    #1;
    check("post_rst_res_valid", 32'(bus.res_valid), 32'h1);
    check("post_rst_res_id",    32'(bus.res_id),    32'h0);
    check("post_rst_res_data",  32'(bus.res_data),  32'h38);
    cyc();
    #1;
    check("post_rst_no_ghost", 32'(bus.res_valid), 32'h0);
    check("post_rst_idle",     32'(bus.busy),      32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
